// File: rtl/inst_rom.sv
// Instruction memory for MyMIPS, filled at run time by a byte-serial valid/ready loader.
// Loader bytes are packed into words; fetch reads are combinational and gated to RUN.
module inst_rom #(
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [31:0]       addr_i,
  output logic [31:0]       inst_o,
  input  logic              ld_start_i,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic [ADDR_W:0]   word_cnt_o,
  output logic              ovf_o,
  output logic              core_rst_o
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state_q, state_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              core_rst_q, core_rst_d;

  logic              acc;
  logic [1:0]        lane;
  logic [31:0]       cur_word;
  logic              mem_we;
  logic [31:0]       mem_q [DEPTH];
  logic [1:0]        unused_addr_lsb;

  assign acc      = ld_valid_i & ready_q & ~ld_start_i;
  assign lane     = BIG_ENDIAN ? (2'd3 - bcnt_q) : bcnt_q;
  // Lanes not yet filled are still zero, so a short final word pads with 0.
  assign cur_word = word_q | (32'(ld_byte_i) << {lane, 3'b000});

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    core_rst_d = core_rst_q;
    mem_we     = 1'b0;
    if (ld_start_i) begin
      state_d    = LOAD;
      bcnt_d     = 2'd0;
      word_d     = 32'h0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      core_rst_d = 1'b1;
    end else if (acc) begin
      if (bcnt_q == 2'd3 || ld_last_i) begin
        bcnt_d = 2'd0;
        word_d = 32'h0;
        // cnt_q's top bit set means exactly DEPTH words stored: drop further words.
        if (!cnt_q[ADDR_W]) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + (ADDR_W+1)'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        bcnt_d = bcnt_q + 2'd1;
        word_d = cur_word;
      end
      if (ld_last_i) begin
        state_d    = RUN;
        core_rst_d = 1'b0;
        done_d     = 1'b1;
      end
    end
    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bcnt_q     <= 2'd0;
      word_q     <= 32'h0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      core_rst_q <= core_rst_d;
    end
  end

  // Array is deliberately outside the reset domain so an image survives rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[cnt_q[ADDR_W-1:0]] <= cur_word;
  end

  assign unused_addr_lsb = addr_i[1:0];

  always_comb begin
    inst_o = 32'h0;
    if (ce_i && state_q == RUN && addr_i[31:ADDR_W+2] == '0)
      inst_o = mem_q[addr_i[ADDR_W+1:2]];
  end

  assign ld_ready_o = ready_q;
  assign ld_done_o  = done_q;
  assign word_cnt_o = cnt_q;
  assign ovf_o      = ovf_q;
  assign core_rst_o = core_rst_q;

endmodule

// File: tb/tb_inst_rom.sv
// Bench for inst_rom: three instances (default, little-endian, 4-word deep) share one loader
// and are checked against a byte-queue model of the image.
module tb_inst_rom;
  logic clk = 1'b0;
  logic rst, ce_i, ld_start_i, ld_valid_i, ld_last_i;
  logic [31:0] addr_i;
  logic [7:0]  ld_byte_i;

  logic [31:0] b_inst, l_inst, s_inst;
  logic        b_rdy, l_rdy, s_rdy, b_done, l_done, s_done;
  logic        b_ovf, l_ovf, s_ovf, b_crst, l_crst, s_crst;
  logic [10:0] b_cnt, l_cnt;
  logic [2:0]  s_cnt;

  always #5 clk = ~clk;

  inst_rom #(.ADDR_W(10), .BIG_ENDIAN(1'b1)) u_big (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(b_inst),
    .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
    .ld_last_i(ld_last_i), .ld_ready_o(b_rdy), .ld_done_o(b_done),
    .word_cnt_o(b_cnt), .ovf_o(b_ovf), .core_rst_o(b_crst));
  inst_rom #(.ADDR_W(10), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(l_inst),
    .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
    .ld_last_i(ld_last_i), .ld_ready_o(l_rdy), .ld_done_o(l_done),
    .word_cnt_o(l_cnt), .ovf_o(l_ovf), .core_rst_o(l_crst));
  inst_rom #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) u_small (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(s_inst),
    .ld_start_i(ld_start_i), .ld_valid_i(ld_valid_i), .ld_byte_i(ld_byte_i),
    .ld_last_i(ld_last_i), .ld_ready_o(s_rdy), .ld_done_o(s_done),
    .word_cnt_o(s_cnt), .ovf_o(s_ovf), .core_rst_o(s_crst));

  int n_cmp = 0;
  int n_err = 0;
  int done_seen;
  logic [7:0] ld_q[$];

  // Reference model: memory images, known-word flags, run flag and expected status.
  logic [31:0] m_big [1024];
  logic [31:0] m_le  [1024];
  bit          k_wide[1024];
  logic [31:0] m_sm  [4];
  bit          k_sm  [4];
  bit          run = 1'b0;
  int          e_cnt_wide, e_cnt_sm;
  bit          e_ovf_wide, e_ovf_sm;

  function automatic logic [31:0] pack(input int w, input bit big);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = (4*w+i < ld_q.size()) ? ld_q[4*w+i] : 8'h00;
    return big ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
  endfunction

  task automatic model_load(input bit finished);
    int nw;
    nw = finished ? (ld_q.size() + 3) / 4 : ld_q.size() / 4;
    for (int w = 0; w < nw; w++) begin
      if (w < 1024) begin m_big[w] = pack(w, 1'b1); m_le[w] = pack(w, 1'b0); k_wide[w] = 1'b1; end
      if (w < 4)    begin m_sm[w]  = pack(w, 1'b1); k_sm[w] = 1'b1; end
    end
    e_cnt_wide = (nw > 1024) ? 1024 : nw;
    e_cnt_sm   = (nw > 4) ? 4 : nw;
    e_ovf_wide = (nw > 1024);
    e_ovf_sm   = (nw > 4);
    run        = finished;
  endtask

  function automatic logic [32:0] exp_wide(input bit le, input logic ce, input logic [31:0] a);
    if (!ce || !run || a[31:12] != 20'h0) return {1'b1, 32'h0};
    return {k_wide[a[11:2]], le ? m_le[a[11:2]] : m_big[a[11:2]]};
  endfunction

  function automatic logic [32:0] exp_small(input logic ce, input logic [31:0] a);
    if (!ce || !run || a[31:4] != 28'h0) return {1'b1, 32'h0};
    return {k_sm[a[3:2]], m_sm[a[3:2]]};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_pulse;
    ld_start_i = 1'b1; tick; ld_start_i = 1'b0;
  endtask

  // Feeds ld_q[0..n-1] with random idle gaps; counts done pulses seen before the last edge.
  task automatic feed(input int n, input bit mark_last);
    done_seen = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid_i = 1'b0; ld_last_i = 1'b0; tick;
        if (b_done | l_done | s_done) done_seen++;
      end
      ld_valid_i = 1'b1; ld_byte_i = ld_q[i]; ld_last_i = mark_last && (i == n-1);
      tick;
      if (i != n-1 && (b_done | l_done | s_done)) done_seen++;
    end
    ld_valid_i = 1'b0; ld_last_i = 1'b0;
  endtask

  task automatic rand_q(input int n);
    ld_q.delete();
    for (int i = 0; i < n; i++) ld_q.push_back(8'($urandom()));
  endtask

  task automatic test_reset;
    rst = 1'b1; ce_i = 1'b1; addr_i = 32'h0;
    ld_start_i = 1'b0; ld_valid_i = 1'b0; ld_byte_i = 8'h0; ld_last_i = 1'b0;
    #3;
    n_cmp++; if (b_rdy !== 1'b0 || b_done !== 1'b0 || b_ovf !== 1'b0) begin n_err++;
      $display("FAIL reset_flags: got rdy=%b done=%b ovf=%b want 0 0 0", b_rdy, b_done, b_ovf); end
    n_cmp++; if (b_crst !== 1'b1 || s_crst !== 1'b1) begin n_err++;
      $display("FAIL reset_core_rst: got %b/%b want 1", b_crst, s_crst); end
    n_cmp++; if (b_cnt !== 11'd0 || s_cnt !== 3'd0) begin n_err++;
      $display("FAIL reset_cnt: got %0d/%0d want 0", b_cnt, s_cnt); end
    repeat (2) tick;
    rst = 1'b0; tick;
    n_cmp++; if (b_inst !== 32'h0 || s_inst !== 32'h0 || b_rdy !== 1'b0 || b_crst !== 1'b1) begin n_err++;
      $display("FAIL idle_after_reset: got inst=%h rdy=%b crst=%b want 0 0 1", b_inst, b_rdy, b_crst); end
  endtask

  task automatic test_load_fetch;
    ld_q = '{8'h34, 8'h01, 8'h00, 8'h10, 8'h34, 8'h02, 8'h00, 8'h20};
    start_pulse;
    n_cmp++; if (b_rdy !== 1'b1 || b_crst !== 1'b1 || b_cnt !== 11'd0) begin n_err++;
      $display("FAIL load_entry: got rdy=%b crst=%b cnt=%0d want 1 1 0", b_rdy, b_crst, b_cnt); end
    feed(8, 1'b1);
    model_load(1'b1);
    n_cmp++; if (b_done !== 1'b1 || b_crst !== 1'b0 || b_rdy !== 1'b0 || done_seen != 0) begin n_err++;
      $display("FAIL last_edge: got done=%b crst=%b rdy=%b early=%0d want 1 0 0 0", b_done, b_crst, b_rdy, done_seen); end
    n_cmp++; if (b_cnt !== 11'd2 || s_cnt !== 3'd2) begin n_err++;
      $display("FAIL load_cnt: got %0d/%0d want 2", b_cnt, s_cnt); end
    ce_i = 1'b1; addr_i = 32'h0; #1;
    n_cmp++; if (b_inst !== 32'h34010010) begin n_err++;
      $display("FAIL fetch0: got %h want 34010010", b_inst); end
    n_cmp++; if (l_inst !== 32'h10000134) begin n_err++;
      $display("FAIL fetch0_le: got %h want 10000134", l_inst); end
    addr_i = 32'h4; #1;
    n_cmp++; if (b_inst !== 32'h34020020) begin n_err++;
      $display("FAIL fetch4: got %h want 34020020", b_inst); end
    tick;
    n_cmp++; if (b_done !== 1'b0) begin n_err++;
      $display("FAIL done_width: got %b want 0", b_done); end
  endtask

  task automatic test_partial;
    ld_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    start_pulse; feed(5, 1'b1); model_load(1'b1);
    n_cmp++; if (b_cnt !== 11'd2 || l_cnt !== 11'd2) begin n_err++;
      $display("FAIL partial_cnt: got %0d/%0d want 2", b_cnt, l_cnt); end
    ce_i = 1'b1; addr_i = 32'h4; #1;
    n_cmp++; if (b_inst !== 32'hEE000000 || l_inst !== 32'h000000EE) begin n_err++;
      $display("FAIL partial_word: got %h/%h want EE000000/000000EE", b_inst, l_inst); end
    addr_i = 32'h0; #1;
    n_cmp++; if (l_inst !== 32'hDDCCBBAA || b_inst !== 32'hAABBCCDD) begin n_err++;
      $display("FAIL partial_full_word: got %h/%h want DDCCBBAA/AABBCCDD", l_inst, b_inst); end
  endtask

  task automatic test_overflow;
    logic [31:0] w0, w3, w4;
    rand_q(20);
    w0 = {ld_q[0], ld_q[1], ld_q[2], ld_q[3]};
    w3 = {ld_q[12], ld_q[13], ld_q[14], ld_q[15]};
    w4 = {ld_q[16], ld_q[17], ld_q[18], ld_q[19]};
    start_pulse; feed(20, 1'b1); model_load(1'b1);
    n_cmp++; if (s_ovf !== 1'b1 || s_cnt !== 3'd4) begin n_err++;
      $display("FAIL ovf_small: got ovf=%b cnt=%0d want 1 4", s_ovf, s_cnt); end
    n_cmp++; if (b_ovf !== 1'b0 || b_cnt !== 11'd5) begin n_err++;
      $display("FAIL ovf_big: got ovf=%b cnt=%0d want 0 5", b_ovf, b_cnt); end
    ce_i = 1'b1; addr_i = 32'h0; #1;
    n_cmp++; if (s_inst !== w0) begin n_err++;
      $display("FAIL ovf_no_wrap: got %h want %h", s_inst, w0); end
    addr_i = 32'hC; #1;
    n_cmp++; if (s_inst !== w3) begin n_err++;
      $display("FAIL ovf_last_slot: got %h want %h", s_inst, w3); end
    addr_i = 32'h10; #1;
    n_cmp++; if (s_inst !== 32'h0 || b_inst !== w4) begin n_err++;
      $display("FAIL ovf_range: got %h/%h want 0/%h", s_inst, b_inst, w4); end
  endtask

  task automatic test_reload_from_run;
    ce_i = 1'b1; addr_i = 32'h0;
    start_pulse; run = 1'b0;
    n_cmp++; if (b_crst !== 1'b1 || s_crst !== 1'b1 || b_inst !== 32'h0 || s_inst !== 32'h0) begin n_err++;
      $display("FAIL reload_enter: got crst=%b inst=%h want 1 0", b_crst, b_inst); end
    n_cmp++; if (s_ovf !== 1'b0 || s_cnt !== 3'd0) begin n_err++;
      $display("FAIL reload_clear: got ovf=%b cnt=%0d want 0 0", s_ovf, s_cnt); end
    rand_q(12); feed(12, 1'b1); model_load(1'b1);
    n_cmp++; if (b_cnt !== 11'd3 || s_crst !== 1'b0) begin n_err++;
      $display("FAIL reload_done: got cnt=%0d crst=%b want 3 0", b_cnt, s_crst); end
  endtask

  task automatic test_addr_gating;
    logic [32:0] e;
    ce_i = 1'b0; addr_i = 32'h0; #1;
    n_cmp++; if (b_inst !== 32'h0 || l_inst !== 32'h0 || s_inst !== 32'h0) begin n_err++;
      $display("FAIL gate_ce: got %h want 0", b_inst); end
    ce_i = 1'b1; addr_i = 32'h00001000; #1;
    n_cmp++; if (b_inst !== 32'h0 || l_inst !== 32'h0) begin n_err++;
      $display("FAIL gate_high_addr: got %h/%h want 0", b_inst, l_inst); end
    addr_i = 32'h6; #1; e = exp_wide(1'b0, 1'b1, 32'h4);
    n_cmp++; if (b_inst !== e[31:0]) begin n_err++;
      $display("FAIL gate_lsb_ignored: got %h want %h", b_inst, e[31:0]); end
  endtask

  task automatic test_restart_reset;
    logic [31:0] w0;
    rand_q(8);
    start_pulse; feed(3, 1'b0);
    ce_i = 1'b1; addr_i = 32'h0; #1;
    n_cmp++; if (b_inst !== 32'h0 || s_inst !== 32'h0) begin n_err++;
      $display("FAIL read_during_load: got %h want 0", b_inst); end
    ld_start_i = 1'b1; ld_valid_i = 1'b1; ld_byte_i = 8'h5A; ld_last_i = 1'b0;
    tick;
    ld_start_i = 1'b0; ld_valid_i = 1'b0;
    n_cmp++; if (b_cnt !== 11'd0 || b_rdy !== 1'b1) begin n_err++;
      $display("FAIL restart: got cnt=%0d rdy=%b want 0 1", b_cnt, b_rdy); end
    rand_q(8); w0 = {ld_q[0], ld_q[1], ld_q[2], ld_q[3]};
    feed(8, 1'b1); model_load(1'b1);
    addr_i = 32'h0; #1;
    n_cmp++; if (b_cnt !== 11'd2 || b_inst !== w0) begin n_err++;
      $display("FAIL restart_image: got cnt=%0d w0=%h want 2 %h", b_cnt, b_inst, w0); end
    rand_q(6);
    start_pulse; feed(6, 1'b0); model_load(1'b0);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (b_rdy !== 1'b0 || b_crst !== 1'b1 || s_rdy !== 1'b0 || s_crst !== 1'b1 || b_cnt !== 11'd0) begin n_err++;
      $display("FAIL async_rst: got rdy=%b crst=%b cnt=%0d want 0 1 0", b_rdy, b_crst, b_cnt); end
    #1 rst = 1'b0;
    tick;
    n_cmp++; if (b_inst !== 32'h0 || b_rdy !== 1'b0) begin n_err++;
      $display("FAIL post_rst_read: got %h want 0", b_inst); end
    rand_q(10); w0 = {ld_q[0], ld_q[1], ld_q[2], ld_q[3]};
    start_pulse; feed(10, 1'b1); model_load(1'b1);
    #1;
    n_cmp++; if (b_cnt !== 11'd3 || b_inst !== w0 || b_crst !== 1'b0) begin n_err++;
      $display("FAIL reload_after_rst: got cnt=%0d w0=%h want 3 %h", b_cnt, b_inst, w0); end
  endtask

  task automatic test_random;
    logic [32:0] eb, el, es;
    for (int it = 0; it < 6; it++) begin
      rand_q($urandom_range(1, 24));
      start_pulse; feed(ld_q.size(), 1'b1); model_load(1'b1);
      n_cmp++; if (b_cnt !== 11'(e_cnt_wide) || l_cnt !== 11'(e_cnt_wide) || s_cnt !== 3'(e_cnt_sm) || s_ovf !== e_ovf_sm || b_ovf !== e_ovf_wide) begin n_err++;
        $display("FAIL rand_status: got %0d/%0d/%0d ovf=%b want %0d/%0d ovf=%b", b_cnt, l_cnt, s_cnt, s_ovf, e_cnt_wide, e_cnt_sm, e_ovf_sm); end
      for (int r = 0; r < 10; r++) begin
        ce_i = ($urandom_range(0, 3) != 0);
        addr_i = ($urandom_range(0, 3) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 31));
        #1;
        eb = exp_wide(1'b0, ce_i, addr_i); el = exp_wide(1'b1, ce_i, addr_i); es = exp_small(ce_i, addr_i);
        if (eb[32]) begin n_cmp++; if (b_inst !== eb[31:0]) begin n_err++;
          $display("FAIL rand_read_big: addr=%h got %h want %h", addr_i, b_inst, eb[31:0]); end end
        if (el[32]) begin n_cmp++; if (l_inst !== el[31:0]) begin n_err++;
          $display("FAIL rand_read_le: addr=%h got %h want %h", addr_i, l_inst, el[31:0]); end end
        if (es[32]) begin n_cmp++; if (s_inst !== es[31:0]) begin n_err++;
          $display("FAIL rand_read_small: addr=%h got %h want %h", addr_i, s_inst, es[31:0]); end end
      end
    end
  endtask

  initial begin
    test_reset;
    test_load_fetch;
    test_partial;
    test_overflow;
    test_reload_from_run;
    test_addr_gating;
    test_restart_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
